// File: rtl/gise_hakem.sv
// gise_hakem: round-robin scheduler that shares one check-in pipeline
// (identity -> baggage -> payment -> aircraft) between four desks.
//
// Ports:
//   saat, reset          clock (rising edge), synchronous active-high reset
//   istek[3:0]           per-desk request, held until that desk's kabul pulse
//   kimlik_no, uyruk,    per-desk passenger fields, desk i in slice i
//   agirlik, bakiye
//   h_basla              one-cycle start pulse to the pipeline
//   h_kimlik_no, h_uyruk, h_agirlik, h_bakiye
//                        captured operands, stable from grant until idle again
//   h_kalkis, h_k_bakiye pipeline verdict and remaining balance, valid with h_bitti
//   h_bitti              pipeline completion pulse
//   kabul[3:0]           one-hot grant pulse
//   sonuc_gecerli        result-valid pulse
//   sonuc_gise, sonuc_kalkis, sonuc_k_bakiye, zaman_asimi
//                        result fields, held until the next result
//   mesgul               high whenever the scheduler is not idle
module gise_hakem #(
    parameter int BIT   = 6,
    parameter int ZAMAN = 64
) (
    input  logic               saat,
    input  logic               reset,
    input  logic [3:0]         istek,
    input  logic [4*BIT-1:0]   kimlik_no,
    input  logic [3:0]         uyruk,
    input  logic [23:0]        agirlik,
    input  logic [35:0]        bakiye,
    output logic               h_basla,
    output logic [BIT-1:0]     h_kimlik_no,
    output logic               h_uyruk,
    output logic [5:0]         h_agirlik,
    output logic [8:0]         h_bakiye,
    input  logic               h_kalkis,
    input  logic [8:0]         h_k_bakiye,
    input  logic               h_bitti,
    output logic [3:0]         kabul,
    output logic               sonuc_gecerli,
    output logic [1:0]         sonuc_gise,
    output logic               sonuc_kalkis,
    output logic [8:0]         sonuc_k_bakiye,
    output logic               zaman_asimi,
    output logic               mesgul
);

    localparam int CW = $clog2(ZAMAN);

    typedef enum logic [1:0] {BOS, BASLAT, BEKLE, SONUC} durum_t;

    durum_t         durum_q, durum_d;
    logic [1:0]     son_q, son_d;
    logic [3:0]     kabul_q, kabul_d;
    logic [CW-1:0]  sayac_q, sayac_d;
    logic [BIT-1:0] hk_q, hk_d;
    logic           hu_q, hu_d;
    logic [5:0]     ha_q, ha_d;
    logic [8:0]     hb_q, hb_d;
    logic [1:0]     sg_q, sg_d;
    logic           sk_q, sk_d;
    logic [8:0]     skb_q, skb_d;
    logic           za_q, za_d;

    // Round-robin pick: scan son+1, son+2, son+3, son (mod 4).
    logic       secim_var;
    logic [1:0] secim;
    logic [1:0] aday;

    always_comb begin
        secim_var = 1'b0;
        secim     = 2'd0;
        aday      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            aday = son_q + 2'(k);
            if (!secim_var && istek[aday]) begin
                secim_var = 1'b1;
                secim     = aday;
            end
        end
    end

    always_comb begin
        durum_d = durum_q;
        son_d   = son_q;
        kabul_d = 4'b0000;
        sayac_d = sayac_q;
        hk_d    = hk_q;
        hu_d    = hu_q;
        ha_d    = ha_q;
        hb_d    = hb_q;
        sg_d    = sg_q;
        sk_d    = sk_q;
        skb_d   = skb_q;
        za_d    = za_q;
        case (durum_q)
            BOS: begin
                if (secim_var) begin
                    hk_d    = kimlik_no[int'(secim)*BIT +: BIT];
                    hu_d    = uyruk[secim];
                    ha_d    = agirlik[int'(secim)*6 +: 6];
                    hb_d    = bakiye[int'(secim)*9 +: 9];
                    son_d   = secim;
                    kabul_d = 4'b0001 << secim;
                    durum_d = BASLAT;
                end
            end
            BASLAT: begin
                // A completion pulse seen here belongs to nobody and is dropped.
                sayac_d = '0;
                durum_d = BEKLE;
            end
            BEKLE: begin
                // Completion takes priority over a timeout on the same cycle.
                if (h_bitti) begin
                    sg_d    = son_q;
                    sk_d    = h_kalkis;
                    skb_d   = h_k_bakiye;
                    za_d    = 1'b0;
                    durum_d = SONUC;
                end else if (sayac_q == CW'(ZAMAN - 1)) begin
                    // Timed out: no departure and the passenger is not charged.
                    sg_d    = son_q;
                    sk_d    = 1'b0;
                    skb_d   = hb_q;
                    za_d    = 1'b1;
                    durum_d = SONUC;
                end else begin
                    sayac_d = sayac_q + CW'(1);
                end
            end
            SONUC: begin
                durum_d = BOS;
            end
            default: begin
                durum_d = BOS;
            end
        endcase
    end

    always_ff @(posedge saat) begin
        if (reset) begin
            durum_q <= BOS;
            son_q   <= 2'd3;
            kabul_q <= 4'b0000;
            sayac_q <= '0;
            hk_q    <= '0;
            hu_q    <= 1'b0;
            ha_q    <= '0;
            hb_q    <= '0;
            sg_q    <= '0;
            sk_q    <= 1'b0;
            skb_q   <= '0;
            za_q    <= 1'b0;
        end else begin
            durum_q <= durum_d;
            son_q   <= son_d;
            kabul_q <= kabul_d;
            sayac_q <= sayac_d;
            hk_q    <= hk_d;
            hu_q    <= hu_d;
            ha_q    <= ha_d;
            hb_q    <= hb_d;
            sg_q    <= sg_d;
            sk_q    <= sk_d;
            skb_q   <= skb_d;
            za_q    <= za_d;
        end
    end

    assign h_basla        = (durum_q == BASLAT);
    assign sonuc_gecerli  = (durum_q == SONUC);
    assign mesgul         = (durum_q != BOS);
    assign kabul          = kabul_q;
    assign h_kimlik_no    = hk_q;
    assign h_uyruk        = hu_q;
    assign h_agirlik      = ha_q;
    assign h_bakiye       = hb_q;
    assign sonuc_gise     = sg_q;
    assign sonuc_kalkis   = sk_q;
    assign sonuc_k_bakiye = skb_q;
    assign zaman_asimi    = za_q;

endmodule
